// File: rtl/ps2_calc_pkg.sv
// Shared constants for the PS/2 scan-code decoder: calculator key codes,
// decoder FSM states and the set-2 prefix and control bytes.
package ps2_calc_pkg;

  // Calculator key codes (0-15 are the hex digits themselves)
  localparam logic [4:0] KEY_ADD  = 5'd16;
  localparam logic [4:0] KEY_SUB  = 5'd17;
  localparam logic [4:0] KEY_MUL  = 5'd18;
  localparam logic [4:0] KEY_DIV  = 5'd19;
  localparam logic [4:0] KEY_EQ   = 5'd20;
  localparam logic [4:0] KEY_BKSP = 5'd21;
  localparam logic [4:0] KEY_CLR  = 5'd22;

  // Prefix tracking states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  // Set-2 prefix bytes
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Keyboard control / status bytes that never carry a key
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  // True for bytes that abort any prefix sequence and produce no event
  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_ECHO) ||
           (b == SC_RESEND) || (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_scancode_map.sv
// Combinational lookup from {extended flag, make code} to a calculator key.
module ps2_scancode_map
  import ps2_calc_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output logic       hit_o,
  output logic [4:0] key_o
);

  // Table lookup; anything not listed is reported as a miss
  always_comb begin
    hit_o = 1'b1;
    key_o = 5'd0;
    case ({ext_i, code_i})
      // main-row digits
      9'h045: key_o = 5'd0;
      9'h016: key_o = 5'd1;
      9'h01E: key_o = 5'd2;
      9'h026: key_o = 5'd3;
      9'h025: key_o = 5'd4;
      9'h02E: key_o = 5'd5;
      9'h036: key_o = 5'd6;
      9'h03D: key_o = 5'd7;
      9'h03E: key_o = 5'd8;
      9'h046: key_o = 5'd9;
      // letters A-F
      9'h01C: key_o = 5'd10;
      9'h032: key_o = 5'd11;
      9'h021: key_o = 5'd12;
      9'h023: key_o = 5'd13;
      9'h024: key_o = 5'd14;
      9'h02B: key_o = 5'd15;
      // keypad digits
      9'h070: key_o = 5'd0;
      9'h069: key_o = 5'd1;
      9'h072: key_o = 5'd2;
      9'h07A: key_o = 5'd3;
      9'h06B: key_o = 5'd4;
      9'h073: key_o = 5'd5;
      9'h074: key_o = 5'd6;
      9'h06C: key_o = 5'd7;
      9'h075: key_o = 5'd8;
      9'h07D: key_o = 5'd9;
      // operators and editing keys
      9'h079: key_o = KEY_ADD;
      9'h07B: key_o = KEY_SUB;
      9'h07C: key_o = KEY_MUL;
      9'h055: key_o = KEY_EQ;
      9'h05A: key_o = KEY_EQ;
      9'h066: key_o = KEY_BKSP;
      9'h076: key_o = KEY_CLR;
      // extended: keypad slash and keypad enter
      9'h14A: key_o = KEY_DIV;
      9'h15A: key_o = KEY_EQ;
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code decoder: strips E0/F0 prefixes, suppresses typematic
// repeats and emits one key_valid pulse per fresh calculator key press.
module ps2_scancode_decoder
  import ps2_calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_W          = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_is_digit,
  output logic       unmapped
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       held_q, held_d;
  logic             held_valid_q, held_valid_d;
  logic [4:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_is_digit_q, key_is_digit_d;
  logic             unmapped_q, unmapped_d;

  logic             make_ev;
  logic             brk_ev;
  logic [8:0]       make_key;
  logic [8:0]       brk_key;
  logic             map_hit;
  logic [4:0]       map_key;

  // Extended flag of the byte now on code_in comes from the prefix state
  assign make_key = {state_q == ST_EXT, code_in};
  assign brk_key  = {state_q == ST_EXT_BRK, code_in};

  ps2_scancode_map u_map (
    .ext_i  (state_q == ST_EXT),
    .code_i (code_in),
    .hit_o  (map_hit),
    .key_o  (map_key)
  );

  // Prefix FSM, timeout, typematic filter and output pulse generation
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    held_d         = held_q;
    held_valid_d   = held_valid_q;
    key_code_d     = key_code_q;
    key_is_digit_d = key_is_digit_q;
    key_valid_d    = 1'b0;
    unmapped_d     = 1'b0;
    make_ev        = 1'b0;
    brk_ev         = 1'b0;

    if (code_valid) begin
      // A new byte always restarts the timeout, even if it would expire now
      cnt_d = '0;
      if (is_ctrl(code_in)) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (code_in == SC_EXT)      state_d = ST_EXT;
            else if (code_in == SC_BRK) state_d = ST_BRK;
            else                        make_ev = 1'b1;
          end
          ST_EXT: begin
            if (code_in == SC_BRK)      state_d = ST_EXT_BRK;
            else if (code_in == SC_EXT) state_d = ST_EXT;
            else begin
              make_ev = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: begin
            brk_ev  = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == TO_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (make_ev && !(held_valid_q && (held_q == make_key))) begin
      held_d       = make_key;
      held_valid_d = 1'b1;
      if (map_hit) begin
        key_valid_d    = 1'b1;
        key_code_d     = map_key;
        key_is_digit_d = ~map_key[4];
      end else begin
        unmapped_d = 1'b1;
      end
    end

    if (brk_ev && held_valid_q && (held_q == brk_key)) begin
      held_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      held_q         <= '0;
      held_valid_q   <= 1'b0;
      key_code_q     <= '0;
      key_valid_q    <= 1'b0;
      key_is_digit_q <= 1'b0;
      unmapped_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      held_q         <= held_d;
      held_valid_q   <= held_valid_d;
      key_code_q     <= key_code_d;
      key_valid_q    <= key_valid_d;
      key_is_digit_q <= key_is_digit_d;
      unmapped_q     <= unmapped_d;
    end
  end

  assign key_code     = key_code_q;
  assign key_valid    = key_valid_q;
  assign key_is_digit = key_is_digit_q;
  assign unmapped     = unmapped_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a short timeout.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] code_in;
  logic       code_valid;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_is_digit;
  logic       unmapped;

  int vectors     = 0;
  int miscompares = 0;

  ps2_scancode_decoder #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_is_digit (key_is_digit),
    .unmapped     (unmapped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare on %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the pulse outputs at the current (falling-edge) sample point
  task automatic expect_out(input string tag, input logic kv, input logic unm,
                            input logic [4:0] code);
    check({tag, ".key_valid"}, 32'(key_valid), 32'(kv));
    check({tag, ".unmapped"}, 32'(unmapped), 32'(unm));
    if (kv) begin
      check({tag, ".key_code"}, 32'(key_code), 32'(code));
      check({tag, ".key_is_digit"}, 32'(key_is_digit), 32'(code < 5'd16));
    end
  endtask

  // One-cycle strobe; returns on the falling edge right after the sampling edge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_in    = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic press(input string tag, input logic [7:0] b, input logic kv,
                       input logic unm, input logic [4:0] code);
    send(b);
    expect_out(tag, kv, unm, code);
    $display("byte %02h -> key_valid=%0b unmapped=%0b key_code=%0d (%s)",
             b, key_valid, unmapped, key_code, tag);
  endtask

  initial begin
    reset      = 1'b1;
    code_in    = 8'h16;
    code_valid = 1'b1;   // must be ignored while in reset
    repeat (3) @(negedge clk);
    check("rst.key_code", 32'(key_code), 32'd0);
    check("rst.key_valid", 32'(key_valid), 32'd0);
    check("rst.key_is_digit", 32'(key_is_digit), 32'd0);
    check("rst.unmapped", 32'(unmapped), 32'd0);
    code_valid = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    expect_out("rst.release", 1'b0, 1'b0, 5'd0);

    // Basic make / break
    press("make16", 8'h16, 1'b1, 1'b0, 5'd1);
    press("brk16.f0", 8'hF0, 1'b0, 1'b0, 5'd0);
    press("brk16.code", 8'h16, 1'b0, 1'b0, 5'd0);
    press("remake16", 8'h16, 1'b1, 1'b0, 5'd1);
    press("rebrk16.f0", 8'hF0, 1'b0, 1'b0, 5'd0);
    press("rebrk16.code", 8'h16, 1'b0, 1'b0, 5'd0);

    // Typematic suppression on A
    press("typ.1", 8'h1C, 1'b1, 1'b0, 5'd10);
    press("typ.2", 8'h1C, 1'b0, 1'b0, 5'd0);
    press("typ.3", 8'h1C, 1'b0, 1'b0, 5'd0);
    press("typ.f0", 8'hF0, 1'b0, 1'b0, 5'd0);
    press("typ.brk", 8'h1C, 1'b0, 1'b0, 5'd0);
    press("typ.again", 8'h1C, 1'b1, 1'b0, 5'd10);
    press("typ.clr.f0", 8'hF0, 1'b0, 1'b0, 5'd0);
    press("typ.clr", 8'h1C, 1'b0, 1'b0, 5'd0);

    // Extended keys
    press("div.e0", 8'hE0, 1'b0, 1'b0, 5'd0);
    press("div", 8'h4A, 1'b1, 1'b0, 5'd19);
    press("divbrk.e0", 8'hE0, 1'b0, 1'b0, 5'd0);
    press("divbrk.f0", 8'hF0, 1'b0, 1'b0, 5'd0);
    press("divbrk", 8'h4A, 1'b0, 1'b0, 5'd0);
    press("kpent.e0", 8'hE0, 1'b0, 1'b0, 5'd0);
    press("kpent", 8'h5A, 1'b1, 1'b0, 5'd20);
    press("ext75.e0", 8'hE0, 1'b0, 1'b0, 5'd0);
    press("ext75", 8'h75, 1'b0, 1'b1, 5'd0);
    check("ext75.code_hold", 32'(key_code), 32'd20);
    press("ext75brk.e0", 8'hE0, 1'b0, 1'b0, 5'd0);
    press("ext75brk.f0", 8'hF0, 1'b0, 1'b0, 5'd0);
    press("ext75brk", 8'h75, 1'b0, 1'b0, 5'd0);

    // Timeout boundary: byte landing on the expiry edge still sees EXT
    press("to14.e0", 8'hE0, 1'b0, 1'b0, 5'd0);
    repeat (14) @(negedge clk);
    press("to14.div", 8'h4A, 1'b1, 1'b0, 5'd19);
    press("to14brk.e0", 8'hE0, 1'b0, 1'b0, 5'd0);
    press("to14brk.f0", 8'hF0, 1'b0, 1'b0, 5'd0);
    press("to14brk", 8'h4A, 1'b0, 1'b0, 5'd0);
    // One cycle later the prefix has expired
    press("to15.e0", 8'hE0, 1'b0, 1'b0, 5'd0);
    repeat (15) @(negedge clk);
    press("to15.4a", 8'h4A, 1'b0, 1'b1, 5'd0);
    press("to15brk.f0", 8'hF0, 1'b0, 1'b0, 5'd0);
    press("to15brk", 8'h4A, 1'b0, 1'b0, 5'd0);

    // Control bytes cancel prefixes and produce nothing
    press("ctl.f0", 8'hF0, 1'b0, 1'b0, 5'd0);
    press("ctl.aa", 8'hAA, 1'b0, 1'b0, 5'd0);
    press("ctl.45", 8'h45, 1'b1, 1'b0, 5'd0);
    press("ctl.fa", 8'hFA, 1'b0, 1'b0, 5'd0);
    press("ctl45brk.f0", 8'hF0, 1'b0, 1'b0, 5'd0);
    press("ctl45brk", 8'h45, 1'b0, 1'b0, 5'd0);
    press("ctl.e0", 8'hE0, 1'b0, 1'b0, 5'd0);
    press("ctl.ee", 8'hEE, 1'b0, 1'b0, 5'd0);
    press("ctl.5a", 8'h5A, 1'b1, 1'b0, 5'd20);

    // Other mapped keys
    press("clr", 8'h76, 1'b1, 1'b0, 5'd22);
    press("bksp", 8'h66, 1'b1, 1'b0, 5'd21);
    press("mul", 8'h7C, 1'b1, 1'b0, 5'd18);
    press("sub", 8'h7B, 1'b1, 1'b0, 5'd17);
    press("kp0", 8'h70, 1'b1, 1'b0, 5'd0);
    press("letB", 8'h32, 1'b1, 1'b0, 5'd11);
    press("kp9", 8'h7D, 1'b1, 1'b0, 5'd9);

    // Back-to-back strobes: one pulse per byte on consecutive cycles
    @(negedge clk);
    code_in    = 8'h16;
    code_valid = 1'b1;
    @(negedge clk);
    code_in = 8'h1E;
    expect_out("b2b.16", 1'b1, 1'b0, 5'd1);
    $display("byte 16 -> key_valid=%0b key_code=%0d (b2b.16)", key_valid, key_code);
    @(negedge clk);
    code_valid = 1'b0;
    expect_out("b2b.1e", 1'b1, 1'b0, 5'd2);
    $display("byte 1E -> key_valid=%0b key_code=%0d (b2b.1e)", key_valid, key_code);
    @(negedge clk);
    expect_out("b2b.after", 1'b0, 1'b0, 5'd0);

    // Reset between F0 and its code byte discards both prefix and held key
    press("add", 8'h79, 1'b1, 1'b0, 5'd16);
    press("rstmid.f0", 8'hF0, 1'b0, 1'b0, 5'd0);
    #2 reset = 1'b1;
    #1;
    check("rstmid.key_code", 32'(key_code), 32'd0);
    check("rstmid.key_is_digit", 32'(key_is_digit), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    press("rstmid.add", 8'h79, 1'b1, 1'b0, 5'd16);
    press("rstmid.29", 8'h29, 1'b0, 1'b1, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard byte reader, which delivers one set-2 scan-code byte per code_valid strobe.
- Strips the E0 (extended) and F0 (break) prefixes and suppresses typematic repeats.
- Maps make codes to calculator key codes: hex digits, operators, equals/enter, backspace and clear.
- Emits a one-cycle key_valid pulse per fresh key press, which the calculator input/operand logic consumes.

Parameters:
- TIMEOUT_CYCLES, 2000000, number of clk cycles a prefix state may wait for its next byte before falling back to IDLE (20 ms at 100 MHz).
- CNT_W, 21, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- code_in  input  8  scan-code byte from the reader; sampled only when code_valid=1.
- code_valid  input  1  one-cycle strobe marking a new byte on code_in.
- key_code  output  5  decoded key; meaningful when key_valid=1.
- key_valid  output  1  one-cycle pulse for each accepted make event.
- key_is_digit  output  1  key_code<16; qualified by key_valid.
- unmapped  output  1  one-cycle pulse when a make code has no mapping.

Behaviour:
- Reset clock and reset:
  - Reset is asynchronous, active-high; clock is clk.
  - On reset: key_code=0, key_valid=0, key_is_digit=0, unmapped=0, state=IDLE, held_valid=0, timeout counter=0.
  - Reset mid-sequence discards any pending prefix or held key.
- Key codes:
  - 0-15 hex digits; 16 ADD, 17 SUB, 18 MUL, 19 DIV, 20 EQ, 21 BKSP, 22 CLR.
- Map, non-extended:
  - Main-row digits: 45,16,1E,26,25,2E,36,3D,3E,46 -> 0-9.
  - Letters: 1C,32,21,23,24,2B -> A-F.
  - Keypad digits: 70,69,72,7A,6B,73,74,6C,75,7D -> 0-9.
  - 79 ADD, 7B SUB, 7C MUL, 55 EQ, 5A EQ, 66 BKSP, 76 CLR.
- Map, extended: E0 4A -> DIV, E0 5A -> EQ. All other extended codes are unmapped.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Per accepted byte:
  - IDLE: E0->EXT; F0->BRK; other bytes are a make event with ext=0, stay IDLE.
  - EXT: F0->EXT_BRK; E0 stays EXT; other bytes are a make event with ext=1, then IDLE.
  - BRK: a byte is a break event with ext=0, then IDLE.
  - EXT_BRK: a byte is a break event with ext=1, then IDLE.
- Control bytes AA, FA, EE, FE, 00, FF are dropped in any state and force IDLE. They generate no event.
- Make event on {ext,code}:
  - If held_valid and held=={ext,code}: typematic repeat, suppressed, no outputs.
  - Else if mapped: key_valid=1, key_code loaded, held<={ext,code}, held_valid=1.
  - Else: unmapped=1, held<={ext,code}, held_valid=1.
- Break event: if held_valid and held matches, held_valid<=0. Any other break is ignored.
- Latency: key_valid and unmapped assert exactly one cycle after the code_valid of the final byte, for one cycle only. key_code holds its value until the next key_valid.
- Timeout:
  - The counter clears on every code_valid and counts only while the state is not IDLE.
  - On reaching TIMEOUT_CYCLES-1, the state goes to IDLE and the counter clears.
  - If code_valid and expiry coincide, code_valid wins and the byte is processed in the current state.
- Back-to-back code_valid on consecutive cycles is supported, with one event per byte.
- code_valid asserted during reset is ignored.

Decomposition:
- Shared package ps2_calc_pkg holds:
  - key code constants (KEY_ADD..KEY_CLR);
  - FSM state enum;
  - scan-code byte constants (SC_EXT=E0, SC_BRK=F0, control bytes).
- One combinational sub-module, ps2_scancode_map: input {ext, code[7:0]}, outputs hit and key[4:0].
- FSM, held-key register and timeout counter live in the top block.

Test Plan:
- Reset, then byte 16 -> key_valid pulse one cycle later, key_code=1, key_is_digit=1; then F0,16 -> no output, held cleared.
- Typematic: 1C,1C,1C,F0,1C,1C -> exactly two key_valid pulses, each key_code=10.
- Extended: E0,4A -> key_code=19; E0,F0,4A -> nothing; E0,5A -> key_code=20; E0,75 -> unmapped pulse, key_valid=0.
- Byte E0 then idle for TIMEOUT_CYCLES (bench with TIMEOUT_CYCLES=16) -> state IDLE; subsequent 4A -> unmapped pulse, not DIV.
- Control byte mid-sequence: F0,AA,45 -> key_code=0 pulse (AA cancels break); FA alone -> no output.
- Async reset asserted between F0 and its code byte -> after release, 29 -> unmapped pulse; 79 -> key_code=16.
